// File: rtl/comparator_serial_n_pkg.sv
// Shared constants for the serial magnitude comparator: FSM encodings,
// result codes packed as {less, equal, greater}, and the cycles-width helper.
package comparator_serial_n_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CMP  = 1'b1;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;

    function automatic int cycles_width(input int nchunk);
        return $clog2(nchunk + 1);
    endfunction

endpackage

// File: rtl/comparator_serial_n_if.sv
// Request/result bundle between a requester (master) and the serial comparator (slave).
interface comparator_serial_n_if
    import comparator_serial_n_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cycles_width(NCHUNK);

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             less;
    logic             equal;
    logic             greater;
    logic [CW-1:0]    cycles;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, less, equal, greater, cycles
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, less, equal, greater, cycles
    );
endinterface

// File: rtl/comparator_chunk.sv
// Combinational CHUNK-bit unsigned magnitude compare; exactly one of lt/eq/gt is high.
module comparator_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             lt,
    output logic             eq,
    output logic             gt
);
    assign lt = (x < y);
    assign eq = (x == y);
    assign gt = (x > y);
endmodule

// File: rtl/comparator_serial_n.sv
// Multi-cycle WIDTH-bit magnitude comparator: scans CHUNK bits per clock from the MSB
// and stops at the first differing chunk. Signed operands are scanned as offset binary.
//
//  state   | meaning
//  ST_IDLE | waiting for start; results held
//  ST_CMP  | scanning chunks, busy high
module comparator_serial_n
    import comparator_serial_n_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    comparator_serial_n_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cycles_width(NCHUNK);
    localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);
    localparam logic [CW-1:0] ALL_CNT  = CW'(NCHUNK);

    logic [0:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       res_q;
    logic [CW-1:0]    cycles_q;
    logic [WIDTH-1:0] msb_flip;
    logic             chunk_lt;
    logic             chunk_eq;
    logic             chunk_gt;

    // Inverting both MSBs maps two's complement onto an unsigned ordering.
    assign msb_flip = {bus.signed_mode, {(WIDTH-1){1'b0}}};

    comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x  (sh_a[WIDTH-1 -: CHUNK]),
        .y  (sh_b[WIDTH-1 -: CHUNK]),
        .lt (chunk_lt),
        .eq (chunk_eq),
        .gt (chunk_gt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= RES_NONE;
            cycles_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        sh_a   <= bus.a ^ msb_flip;
                        sh_b   <= bus.b ^ msb_flip;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (!chunk_eq) begin
                        res_q    <= {chunk_lt, 1'b0, chunk_gt};
                        cycles_q <= cnt + 1'b1;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (cnt == LAST_IDX) begin
                        res_q    <= RES_EQ;
                        cycles_q <= ALL_CNT;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        sh_a <= sh_a << CHUNK;
                        sh_b <= sh_b << CHUNK;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.less    = res_q[2];
    assign bus.equal   = res_q[1];
    assign bus.greater = res_q[0];
    assign bus.cycles  = cycles_q;
endmodule
